// File: rtl/count_seq_checker.sv
// Checks that a 4-bit up-counter advances by exactly one per clock.
// Locks after LOCK_N good steps and then reports errors and 15->0 wraps.
module count_seq_checker #(
    parameter int LOCK_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       count_in,
    input  logic             chk_en,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_N);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     state;
    state_t     state_next;
    logic [3:0] prev;
    logic [3:0] run;
    logic [3:0] run_next;
    logic       match;
    logic       err_det;
    logic       wrap_det;

    // 4-bit compare makes 0 after 15 a match
    assign match = (count_in == prev + 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            run   <= '0;
        end else begin
            state <= state_next;
            run   <= run_next;
        end
    end

    always_comb begin
        state_next = state;
        run_next   = run;
        if (!chk_en) begin
            state_next = IDLE;
            run_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = SYNC;
                    run_next   = '0;
                end
                SYNC: begin
                    if (!match) begin
                        run_next = '0;
                    end else if (run + 4'd1 == LOCK_RUN) begin
                        state_next = LOCKED;
                        run_next   = '0;
                    end else begin
                        run_next = run + 4'd1;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state_next = SYNC;
                        run_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    run_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        err_det  = chk_en && (state == LOCKED) && !match;
        wrap_det = chk_en && (state == LOCKED) && match &&
                   (prev == 4'hF) && (count_in == 4'h0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            prev      <= count_in;
            locked    <= (state_next == LOCKED);
            err_pulse <= err_det;
            if (wrap_det && wrap_cnt != CNT_MAX)
                wrap_cnt <= wrap_cnt + CNT_W'(1);
            // a clear coinciding with an error leaves exactly that error
            if (clr_err) begin
                err_cnt    <= err_det ? CNT_W'(1) : '0;
                err_sticky <= err_det;
            end else begin
                if (err_det && err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + CNT_W'(1);
                if (err_det)
                    err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus random traffic
// compared against a history-based reference model.
module tb_count_seq_checker;

    localparam int LOCK_N = 2;
    localparam int CNT_W  = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       count_in = '0;
    logic             chk_en = 1'b0;
    logic             clr_err = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic             err_sticky;
    logic [CNT_W-1:0] wrap_cnt;
    logic [CNT_W-1:0] err_cnt;

    int total = 0;
    int bad = 0;

    int m_prev, m_streak, m_wrap, m_err;
    bit m_active, m_locked, m_sticky, m_pulse;

    count_seq_checker #(.LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .count_in(count_in),
        .chk_en(chk_en), .clr_err(clr_err), .locked(locked),
        .err_pulse(err_pulse), .err_sticky(err_sticky),
        .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit good;
        good = (int'(count_in) == (m_prev + 1) % 16);
        if (reset) begin
            m_prev = 0; m_streak = 0; m_wrap = 0; m_err = 0;
            m_active = 0; m_locked = 0; m_sticky = 0; m_pulse = 0;
        end else begin
            m_pulse = 0;
            if (clr_err) begin
                m_err = 0;
                m_sticky = 0;
            end
            if (!chk_en) begin
                m_active = 0;
                m_locked = 0;
            end else if (!m_active) begin
                m_active = 1;
                m_streak = 0;
                m_locked = 0;
            end else if (m_locked) begin
                if (good) begin
                    if (m_prev == 15 && count_in == 0 && m_wrap < MAXC)
                        m_wrap++;
                end else begin
                    m_pulse = 1;
                    m_sticky = 1;
                    if (m_err < MAXC) m_err++;
                    m_locked = 0;
                    m_streak = 0;
                end
            end else begin
                m_streak = good ? m_streak + 1 : 0;
                if (m_streak >= LOCK_N) begin
                    m_locked = 1;
                    m_streak = 0;
                end
            end
            m_prev = int'(count_in);
        end
    endtask

    task automatic drive(input logic r, input logic e,
                         input logic c, input logic [3:0] v);
        reset = r; chk_en = e; clr_err = c; count_in = v;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'($urandom), 1'($urandom), 4'($urandom));
        total++;
        if ({locked, err_pulse, err_sticky} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000",
                     {locked, err_pulse, err_sticky});
        end
        total++;
        if (wrap_cnt !== '0 || err_cnt !== '0) begin
            bad++;
            $display("FAIL reset_cnts got wrap=%0d err=%0d want 0/0",
                     wrap_cnt, err_cnt);
        end
    endtask

    task automatic test_lock();
        logic want [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(i));
            total++;
            if (locked !== want[i] || err_pulse !== 1'b0) begin
                bad++;
                $display("FAIL lock_seq[%0d] got lk=%b ep=%b want lk=%b ep=0",
                         i, locked, err_pulse, want[i]);
            end
        end
    endtask

    task automatic test_wrap();
        for (int v = 4; v < 16; v++)
            drive(1'b0, 1'b1, 1'b0, 4'(v));
        total++;
        if (wrap_cnt !== 2'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL wrap_before got wrap=%0d lk=%b want 0/1",
                     wrap_cnt, locked);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        total++;
        if (wrap_cnt !== 2'd1 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL wrap_after got wrap=%0d ep=%b want 1/0",
                     wrap_cnt, err_pulse);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd1);
        total++;
        if (wrap_cnt !== 2'd1 || locked !== 1'b1 || err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL wrap_hold got wrap=%0d lk=%b st=%b want 1/1/0",
                     wrap_cnt, locked, err_sticky);
        end
    endtask

    task automatic test_error();
        for (int v = 2; v <= 6; v++)
            drive(1'b0, 1'b1, 1'b0, 4'(v));
        drive(1'b0, 1'b1, 1'b0, 4'd6);
        total++;
        if ({err_pulse, err_sticky, locked} !== 3'b110 || err_cnt !== 2'd1) begin
            bad++;
            $display("FAIL held_err got ep/st/lk=%b cnt=%0d want 110/1",
                     {err_pulse, err_sticky, locked}, err_cnt);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd7);
        total++;
        if (err_pulse !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL after_err got ep=%b lk=%b want 0/0",
                     err_pulse, locked);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd8);
        total++;
        if (locked !== 1'b1 || err_cnt !== 2'd1) begin
            bad++;
            $display("FAIL relock got lk=%b cnt=%0d want 1/1", locked, err_cnt);
        end
    endtask

    task automatic test_clr_same_edge();
        drive(1'b0, 1'b1, 1'b0, 4'd9);
        drive(1'b0, 1'b1, 1'b1, 4'd3);
        total++;
        if (err_cnt !== 2'd1 || err_sticky !== 1'b1 || err_pulse !== 1'b1) begin
            bad++;
            $display("FAIL clr_with_err got cnt=%0d st=%b ep=%b want 1/1/1",
                     err_cnt, err_sticky, err_pulse);
        end
        drive(1'b0, 1'b1, 1'b1, 4'd4);
        total++;
        if (err_cnt !== 2'd0 || err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL clr_alone got cnt=%0d st=%b want 0/0",
                     err_cnt, err_sticky);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] v;
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b0, 4'(i));
        v = 4'd2;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, v);
            v = v + 4'd1; drive(1'b0, 1'b1, 1'b0, v);
            v = v + 4'd1; drive(1'b0, 1'b1, 1'b0, v);
        end
        total++;
        if (err_cnt !== 2'd3 || locked !== 1'b1 || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_sat got cnt=%0d lk=%b st=%b want 3/1/1",
                     err_cnt, locked, err_sticky);
        end
        drive(1'b0, 1'b0, 1'b0, v + 4'd5);
        total++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== 2'd3 ||
            err_sticky !== 1'b1 || wrap_cnt !== 2'd0) begin
            bad++;
            $display("FAIL disable got lk=%b ep=%b cnt=%0d st=%b wrap=%0d want 0/0/3/1/0",
                     locked, err_pulse, err_cnt, err_sticky, wrap_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        int errs;
        v = '0;
        errs = 0;
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) == 0) ? 4'($urandom) : v + 4'd1;
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) >= 4,
                  $urandom_range(0, 99) < 4, v);
            total++;
            if (locked !== m_locked || err_pulse !== m_pulse ||
                err_sticky !== m_sticky || int'(wrap_cnt) != m_wrap ||
                int'(err_cnt) != m_err) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL rand[%0d] got lk=%b ep=%b st=%b w=%0d e=%0d want %b %b %b %0d %0d",
                             i, locked, err_pulse, err_sticky, wrap_cnt, err_cnt,
                             m_locked, m_pulse, m_sticky, m_wrap, m_err);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_clr_same_edge();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 The block SHALL have parameter LOCK_N, default 2: consecutive correct increments required to lock (range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the wrap and error statistics counters.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port count_in  input  4  sample of the upstream 4-bit up-counter, one sample per clk.
REQ-006 Port chk_en  input  1  checking enable; low forces IDLE.
REQ-007 Port clr_err  input  1  single-cycle clear of err_sticky and err_cnt.
REQ-008 Port locked  output  1  high while the state is LOCKED.
REQ-009 Port err_pulse  output  1  one-cycle pulse per sequence error detected in LOCKED.
REQ-010 Port err_sticky  output  1  set by any error; held until clr_err or reset.
REQ-011 Port wrap_cnt  output  CNT_W  number of 15->0 wraps seen while LOCKED, saturating.
REQ-012 Port err_cnt  output  CNT_W  number of errors seen while LOCKED, saturating.

Function
REQ-013 prev SHALL be a 4-bit register loaded with count_in on every clock edge not in reset, regardless of state.
REQ-014 expected SHALL be (prev + 1) mod 16; match SHALL be (count_in == expected), so a sample of 0 after 15 SHALL be a match.
REQ-015 The FSM SHALL have exactly three states: IDLE, SYNC, LOCKED.
REQ-016 IDLE: if chk_en=1, the next state SHALL be SYNC with run=0; otherwise the state SHALL remain IDLE.
REQ-017 SYNC: on a match, run SHALL increment; on a mismatch, run SHALL be cleared to 0; when run+1 reaches LOCK_N on a match, the next state SHALL be LOCKED.
REQ-018 SYNC SHALL NOT raise errors or update wrap_cnt or err_cnt.
REQ-019 LOCKED with a match SHALL remain LOCKED; if additionally prev=15 and count_in=0, wrap_cnt SHALL increment, saturating at all-ones.
REQ-020 LOCKED with a mismatch SHALL, on the same edge, set err_pulse=1 for one cycle, increment err_cnt (saturating), set err_sticky, and move to SYNC with run=0.
REQ-021 A held (unchanged) count, any skip, and any backward jump SHALL each count as a mismatch.
REQ-022 chk_en=0 in any state SHALL force the next state to IDLE; wrap_cnt, err_cnt and err_sticky SHALL keep their values.
REQ-023 All outputs SHALL be registered. locked SHALL be 1 exactly in the cycles after the edge that enters LOCKED, up to and including the edge that leaves it.
REQ-024 clr_err=1 SHALL clear err_sticky and err_cnt on that edge. If an error is detected on the same edge, err_cnt SHALL become 1 and err_sticky SHALL become 1.
REQ-025 clr_err SHALL NOT affect wrap_cnt, the state, or err_pulse.
REQ-026 Latency: an error sample present at count_in before edge k SHALL produce err_pulse high from edge k to edge k+1.

Reset
REQ-027 When reset=1 on an edge: state SHALL become IDLE; prev, run, wrap_cnt and err_cnt SHALL become 0; locked, err_pulse and err_sticky SHALL become 0.
REQ-028 Reset SHALL take priority over chk_en and clr_err.
REQ-029 Reset asserted mid-LOCKED SHALL return the block to IDLE without generating err_pulse.

Verification
REQ-030 Reset held for 2 edges with random inputs -> all outputs 0 and state IDLE.
REQ-031 chk_en=1, count_in = 0,1,2,3,..., LOCK_N=2 -> SYNC after edge 1, LOCKED after edge 3, err_pulse stays 0.
REQ-032 LOCKED; count_in runs 14,15,0,1 -> wrap_cnt 0->1 after the 0 sample, no error.
REQ-033 LOCKED; count_in runs 5,6,6,7,8 -> one err_pulse after the second 6, err_cnt=1, err_sticky=1, locked drops, relock after 2 further matches.
REQ-034 err_sticky=1 with clr_err=1 on the same edge as a new mismatch -> err_cnt=1, err_sticky=1. Then clr_err alone -> err_cnt=0, err_sticky=0.
REQ-035 CNT_W=2 with 5 errors -> err_cnt saturates at 3. Drop chk_en -> IDLE next edge with counters held.
